// File: rtl/shftreg_window_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : shftreg_window_sched_if
// Description : Request/stream/window bundle between the bitstream
//               requesters, the shared shift-window scheduler and the
//               downstream window consumer.
//               master = scheduler side, slave = requesters + consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface shftreg_window_sched_if #(
   parameter int N    = 8,
   parameter int M    = 4,
   parameter int IDXW = 2
);
   logic [M-1:0]    REQ;        // per-requester window request (level)
   logic [M-1:0]    IN;         // per-requester stochastic serial bit
   logic [M-1:0]    GRANT;      // one-hot grant, high for the whole shift phase
   logic [N-1:0]    WIN_OUT;    // captured window, bit 0 newest
   logic [IDXW-1:0] WIN_SRC;    // owner of WIN_OUT
   logic            WIN_VALID;  // captured window available
   logic            WIN_READY;  // consumer accepts the window
   logic            BUSY;       // scheduler not idle

   modport master (
      input  REQ, IN, WIN_READY,
      output GRANT, WIN_OUT, WIN_SRC, WIN_VALID, BUSY
   );

   modport slave (
      output REQ, IN, WIN_READY,
      input  GRANT, WIN_OUT, WIN_SRC, WIN_VALID, BUSY
   );
endinterface
`default_nettype wire

// File: rtl/shftreg_window_sched.sv
`default_nettype none
// ============================================================================
// Module      : shftreg_window_sched
// Description : Round-robin scheduler sharing one N-bit serial-to-parallel
//               shift window among M stochastic bitstream requesters.
//               A granted stream is shifted in for exactly N cycles, then the
//               window is offered with its source tag on a valid/ready
//               handshake. Every output is a flop; REQ and WIN_READY only
//               reach outputs through registers.
//               Legal parameters: N >= 2, M >= 2, 2**IDXW >= M, 2**CW >= N.
// Revision    : 1.0 - initial release
// ============================================================================
module shftreg_window_sched #(
   parameter int N    = 8,
   parameter int M    = 4,
   parameter int IDXW = 2,
   parameter int CW   = 3
) (
   input wire CLK,
   input wire RESET,
   shftreg_window_sched_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [CW-1:0]   c_last_cnt = CW'(N - 1);
   localparam logic [IDXW-1:0] c_last_rst = IDXW'(M - 1);
   localparam logic [M-1:0]    c_one_hot0 = {{(M-1){1'b0}}, 1'b1};

   state_t          r_state;
   logic [IDXW-1:0] r_sel;        // index currently being shifted
   logic [IDXW-1:0] r_last;       // round-robin pointer (last granted/aborted)
   logic [N-1:0]    r_win;        // working shift window
   logic [CW-1:0]   r_cnt;        // shift edges already taken
   logic [M-1:0]    r_grant;
   logic [N-1:0]    r_win_out;    // last completed capture
   logic [IDXW-1:0] r_win_src;
   logic            r_win_valid;
   logic            r_busy;

   // Arbitration: the search is split into the indices above r_last (tried
   // first) and the wrap-around part at or below r_last, which gives the
   // LAST+1, LAST+2, ... (mod M) order without any modulo indexing.
   logic            w_any_hi;
   logic            w_any_lo;
   logic [IDXW-1:0] w_hi;
   logic [IDXW-1:0] w_lo;
   logic            w_any;
   logic [IDXW-1:0] w_winner;
   logic [M-1:0]    w_winner_oh;

   // Select the next requester in round-robin order after r_last.
   always_comb begin
      w_any_hi = 1'b0;
      w_any_lo = 1'b0;
      w_hi     = '0;
      w_lo     = '0;
      for (int j = 0; j < M; j++) begin
         if (bus.REQ[j] && (IDXW'(j) > r_last) && !w_any_hi) begin
            w_any_hi = 1'b1;
            w_hi     = IDXW'(j);
         end
         if (bus.REQ[j] && (IDXW'(j) <= r_last) && !w_any_lo) begin
            w_any_lo = 1'b1;
            w_lo     = IDXW'(j);
         end
      end
   end

   assign w_any       = w_any_hi | w_any_lo;
   assign w_winner    = w_any_hi ? w_hi : w_lo;
   assign w_winner_oh = c_one_hot0 << w_winner;

   // The grant is one-hot on the selected stream throughout SHIFT, so masking
   // with it picks that stream's request and bit without a variable index.
   logic         w_req_sel;
   logic         w_in_sel;
   logic [N-1:0] w_shifted;

   assign w_req_sel = |(bus.REQ & r_grant);
   assign w_in_sel  = |(bus.IN  & r_grant);
   assign w_shifted = {r_win[N-2:0], w_in_sel};

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_last      <= c_last_rst;
         r_win       <= '0;
         r_cnt       <= '0;
         r_grant     <= '0;
         r_win_out   <= '0;
         r_win_src   <= '0;
         r_win_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state <= SHIFT;
                  r_sel   <= w_winner;
                  r_last  <= w_winner;
                  r_grant <= w_winner_oh;
                  r_win   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (!w_req_sel) begin
                  // Requester withdrew: drop the partial window. r_last keeps
                  // the aborted index so the next search starts after it.
                  r_state <= IDLE;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_win <= w_shifted;
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == c_last_cnt) begin
                     r_state     <= HOLD;
                     r_grant     <= '0;
                     r_win_out   <= w_shifted;
                     r_win_src   <= r_sel;
                     r_win_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               // Requests are ignored here; WIN_OUT stays until the next capture.
               if (bus.WIN_READY) begin
                  r_state     <= IDLE;
                  r_win_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_grant     <= '0;
               r_win_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.GRANT     = r_grant;
   assign bus.WIN_OUT   = r_win_out;
   assign bus.WIN_SRC   = r_win_src;
   assign bus.WIN_VALID = r_win_valid;
   assign bus.BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_shftreg_window_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_shftreg_window_sched
// Description : Self-checking bench for shftreg_window_sched. Directed
//               stimulus pushes hand-computed windows into a scoreboard queue;
//               a monitor pops and compares on every new WIN_VALID.
//               Each requester r streams pat[r] MSB first while it is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shftreg_window_sched;

   localparam int N    = 8;
   localparam int M    = 4;
   localparam int IDXW = 2;
   localparam int CW   = 3;

   typedef struct packed {
      logic [N-1:0]    win;
      logic [IDXW-1:0] src;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   logic m_prev   = 1'b0;
   int   k [M];
   logic [N-1:0] pat [M];
   exp_t q [$];

   shftreg_window_sched_if #(.N(N), .M(M), .IDXW(IDXW)) bus ();

   shftreg_window_sched #(.N(N), .M(M), .IDXW(IDXW), .CW(CW)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.master)
   );

   always #5 CLK = ~CLK;

   // Free-running cycle counter used for throughput measurements.
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic push_exp(input logic [N-1:0] w, input logic [IDXW-1:0] s);
      exp_t e;
      e.win = w;
      e.src = s;
      q.push_back(e);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.WIN_VALID && n < 60) begin
         tick(1);
         n++;
      end
      check(name, 32'(bus.WIN_VALID), 32'd1);
   endtask

   task automatic wait_grant(input string name, input logic [M-1:0] exp);
      int n = 0;
      while (bus.GRANT == '0 && n < 60) begin
         tick(1);
         n++;
      end
      check(name, 32'(bus.GRANT), 32'(exp));
   endtask

   // Stream driver: while granted, present pattern bits MSB first.
   initial begin
      bus.IN = '0;
      for (int r = 0; r < M; r++) k[r] = 0;
      forever begin
         @(negedge CLK);
         for (int r = 0; r < M; r++) begin
            if (bus.GRANT[r]) begin
               if (k[r] < N) begin
                  bus.IN[r] = pat[r][N-1-k[r]];
                  k[r]++;
               end
            end else begin
               k[r] = 0;
               bus.IN[r] = pat[r][N-1];
            end
         end
      end
   end

   // Scoreboard monitor: compare each newly presented window.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (bus.WIN_VALID && !m_prev) begin
            check("sb_expected_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("sb_win_out", 32'(bus.WIN_OUT), 32'(e.win));
               check("sb_win_src", 32'(bus.WIN_SRC), 32'(e.src));
            end
         end
         m_prev = bus.WIN_VALID;
      end
   end

   // Directed scenario sequence.
   initial begin
      int last_cyc;
      logic [M-1:0] eg;
      RESET         = 1'b1;
      bus.REQ       = '0;
      bus.WIN_READY = 1'b1;
      for (int r = 0; r < M; r++) pat[r] = '0;
      tick(3);
      RESET = 1'b0;
      check("rst_grant", 32'(bus.GRANT), 32'd0);
      check("rst_win_out", 32'(bus.WIN_OUT), 32'd0);
      check("rst_win_src", 32'(bus.WIN_SRC), 32'd0);
      check("rst_valid", 32'(bus.WIN_VALID), 32'd0);
      check("rst_busy", 32'(bus.BUSY), 32'd0);

      // Single window from requester 0, pattern 1,0,1,1,0,0,1,0.
      pat[0] = 8'b1011_0010;
      push_exp(8'b1011_0010, 2'd0);
      bus.REQ = 4'b0001;
      for (int i = 0; i < N; i++) begin
         tick(1);
         check("t1_grant", 32'(bus.GRANT), 32'h1);
      end
      tick(1);
      check("t1_valid", 32'(bus.WIN_VALID), 32'd1);
      check("t1_grant_off", 32'(bus.GRANT), 32'd0);
      check("t1_win_out", 32'(bus.WIN_OUT), 32'hB2);
      bus.REQ = '0;
      tick(1);
      check("t1_valid_drop", 32'(bus.WIN_VALID), 32'd0);
      check("t1_idle", 32'(bus.BUSY), 32'd0);

      // All requesting, consumer always ready: order 0,1,2,3,0 every N+2 cycles.
      RESET = 1'b1;
      tick(1);
      RESET  = 1'b0;
      pat[0] = 8'hB2;
      pat[1] = 8'hC3;
      pat[2] = 8'h0F;
      pat[3] = 8'h81;
      for (int w = 0; w < 5; w++) push_exp(pat[w % M], IDXW'(w % M));
      bus.REQ  = 4'b1111;
      last_cyc = 0;
      for (int w = 0; w < 5; w++) begin
         eg = 4'b0001 << (w % M);
         wait_grant("t2_grant_order", eg);
         wait_valid("t2_valid");
         if (w > 0) check("t2_period", 32'(cyc - last_cyc), 32'(N + 2));
         last_cyc = cyc;
      end
      bus.REQ = '0;
      tick(2);
      check("t2_idle", 32'(bus.BUSY), 32'd0);

      // Back-pressure: window held stable for 5 cycles, requests ignored.
      push_exp(8'hC3, 2'd1);
      bus.WIN_READY = 1'b0;
      bus.REQ       = 4'b0010;
      wait_grant("t3_grant", 4'b0010);
      wait_valid("t3_valid");
      bus.REQ = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("t3_hold_out", 32'(bus.WIN_OUT), 32'hC3);
         check("t3_hold_src", 32'(bus.WIN_SRC), 32'd1);
         check("t3_hold_busy", 32'(bus.BUSY), 32'd1);
         check("t3_hold_nogrant", 32'(bus.GRANT), 32'd0);
         check("t3_hold_valid", 32'(bus.WIN_VALID), 32'd1);
      end
      bus.WIN_READY = 1'b1;
      tick(1);
      check("t3_valid_drop", 32'(bus.WIN_VALID), 32'd0);
      check("t3_idle", 32'(bus.BUSY), 32'd0);
      check("t3_out_kept", 32'(bus.WIN_OUT), 32'hC3);
      bus.REQ = '0;
      tick(1);

      // Abort: requester 2 withdraws after 3 shifts, requester 3 wins next.
      pat[2] = 8'hFF;
      pat[3] = 8'h81;
      push_exp(8'h81, 2'd3);
      bus.REQ = 4'b1100;
      wait_grant("t4_grant2", 4'b0100);
      tick(3);
      bus.REQ = 4'b1000;
      tick(1);
      check("t4_abort_grant", 32'(bus.GRANT), 32'd0);
      check("t4_abort_valid", 32'(bus.WIN_VALID), 32'd0);
      check("t4_abort_busy", 32'(bus.BUSY), 32'd0);
      tick(1);
      check("t4_grant3", 32'(bus.GRANT), 32'h8);
      wait_valid("t4_valid");
      bus.REQ = '0;
      tick(2);

      // Reset mid-shift (counter = 4), then pointer back to requester 0.
      pat[0] = 8'hAA;
      bus.REQ = 4'b0001;
      wait_grant("t5_grant", 4'b0001);
      tick(4);
      RESET = 1'b1;
      tick(1);
      check("t5_rst_grant", 32'(bus.GRANT), 32'd0);
      check("t5_rst_win_out", 32'(bus.WIN_OUT), 32'd0);
      check("t5_rst_win_src", 32'(bus.WIN_SRC), 32'd0);
      check("t5_rst_valid", 32'(bus.WIN_VALID), 32'd0);
      check("t5_rst_busy", 32'(bus.BUSY), 32'd0);
      RESET  = 1'b0;
      pat[0] = 8'h00;
      pat[1] = 8'hFF;
      push_exp(8'h00, 2'd0);
      bus.REQ = 4'b1111;
      tick(1);
      check("t5_regrant0", 32'(bus.GRANT), 32'h1);

      // Only the granted stream is sampled: IN[1]=1 must not leak in.
      bus.REQ = 4'b0001;
      wait_valid("t6_valid");
      check("t6_win_out", 32'(bus.WIN_OUT), 32'd0);
      bus.REQ = '0;
      tick(3);
      check("sb_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop in case the scenario stalls outside a bounded wait.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
